// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: load/store funct3 codes, opcodes used on the data port,
// and the state encoding of the data-memory responder.
package rv32i_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    localparam logic [6:0] OPCODE_LOAD = 7'b0000011;
    localparam logic [6:0] OPCODE_S    = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I loads/stores: byte enables, replicated store word,
// extended load value, and illegal-funct3 / misalignment flags. Purely combinational.
module dmem_lane_align
    import rv32i_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        illegal,
    output logic        misaligned
);

    logic [1:0]  offset;
    logic [31:0] rshift;

    // Offending low address bits are dropped here; trapping is decided by the caller.
    always_comb begin
        offset  = addr_lo;
        byte_en = 4'b0001 << addr_lo;
        wword   = {4{wdata[7:0]}};
        case (funct3[1:0])
            2'b01: begin
                offset  = {addr_lo[1], 1'b0};
                byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword   = {2{wdata[15:0]}};
            end
            2'b10: begin
                offset  = 2'b00;
                byte_en = 4'b1111;
                wword   = wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        if (we) begin
            illegal = !(funct3 inside {FUNCT3_SB, FUNCT3_SH, FUNCT3_SW});
        end else begin
            illegal = !(funct3 inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU});
        end
    end

    assign rshift = rword >> {offset, 3'b000};

    always_comb begin
        rdata = 32'h0;
        case (funct3)
            FUNCT3_LB:  rdata = {{24{rshift[7]}}, rshift[7:0]};
            FUNCT3_LH:  rdata = {{16{rshift[15]}}, rshift[15:0]};
            FUNCT3_LW:  rdata = rshift;
            FUNCT3_LBU: rdata = {24'h0, rshift[7:0]};
            FUNCT3_LHU: rdata = {16'h0, rshift[15:0]};
            default:    rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the RV32I core: one request at a time, LATENCY wait states,
// byte/half/word access. Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses.
module dmem_responder
    import rv32i_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    dmem_state_e state_reg, state_next;
    logic [3:0]  cnt_reg;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] wdata_reg;
    logic        rsp_valid_reg;
    logic [31:0] rsp_rdata_reg;
    logic        rsp_err_reg;

    logic        cur_we;
    logic [31:0] cur_addr;
    logic [2:0]  cur_funct3;
    logic [31:0] cur_wdata;
    logic [IDX_W-1:0] word_idx;
    logic        in_range;
    logic        access_err;
    logic        enter_resp;
    logic        mem_wr;
    logic [31:0] rword;
    logic [3:0]  byte_en;
    logic [31:0] wword;
    logic [31:0] load_data;
    logic        illegal;
    logic        misaligned;

    assign req_ready = (state_reg == IDLE) && !rst;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

    // With LATENCY=0 the access completes on the accept edge, so use the live request.
    always_comb begin
        if (state_reg == IDLE) begin
            cur_we     = req_we;
            cur_addr   = req_addr;
            cur_funct3 = req_funct3;
            cur_wdata  = req_wdata;
        end else begin
            cur_we     = we_reg;
            cur_addr   = addr_reg;
            cur_funct3 = funct3_reg;
            cur_wdata  = wdata_reg;
        end
    end

    // BASE_ADDR is aligned to the array size, so range is a compare of the upper bits.
    assign in_range   = (cur_addr[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]);
    assign word_idx   = cur_addr[IDX_W+1:2];
    assign access_err = !in_range || illegal || (TRAP_EN && misaligned);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = (LATENCY > 0) ? WAIT : RESP;
            WAIT:    if (cnt_reg == 4'd0) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_resp = (state_next == RESP) && (state_reg != RESP);
    assign mem_wr     = enter_resp && !rst && cur_we && !access_err;

    dmem_lane_align u_lane_align (
        .we         (cur_we),
        .funct3     (cur_funct3),
        .addr_lo    (cur_addr[1:0]),
        .wdata      (cur_wdata),
        .rword      (rword),
        .byte_en    (byte_en),
        .wword      (wword),
        .rdata      (load_data),
        .illegal    (illegal),
        .misaligned (misaligned)
    );

    // One byte-wide array per lane keeps byte writes free of read-modify-write.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            always_ff @(posedge clk) begin
                if (mem_wr && byte_en[gi]) begin
                    lane_mem[word_idx] <= wword[8*gi +: 8];
                end
            end
            assign rword[8*gi +: 8] = lane_mem[word_idx];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (state_reg == IDLE && req_valid) begin
            we_reg     <= req_we;
            addr_reg   <= req_addr;
            funct3_reg <= req_funct3;
            wdata_reg  <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'h0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE) begin
                cnt_reg <= CNT_INIT;
            end else if (state_reg == WAIT && cnt_reg != 4'd0) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (enter_resp) begin
                rsp_valid_reg <= 1'b1;
                rsp_err_reg   <= access_err;
                rsp_rdata_reg <= (access_err || cur_we) ? 32'h0 : load_data;
            end else if (state_reg == RESP && rsp_ready) begin
                rsp_valid_reg <= 1'b0;
                rsp_rdata_reg <= 32'h0;
                rsp_err_reg   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: byte-level reference memory, per-cycle
// response compare, directed load/store vectors with literal expectations.
module tb_dmem_responder;

    localparam int          DEPTH   = 1024;
    localparam logic [31:0] BASE    = 32'h0000_0000;
    localparam int          LAT     = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t expq[$];

    logic [7:0] mdl [0:4*DEPTH-1];

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .LATENCY     (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: access width from funct3, range/legality/alignment rules, little-endian bytes.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int     n;
        longint off;
        longint v;
        bit     legal;
        bit     mis;
        int     a;
        n     = 1 << f3[1:0];
        off   = longint'(addr) - longint'(BASE);
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = legal && ((addr % n) != 0);
        err   = !legal || (off < 0) || (off >= 4 * DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
        err = err || mis;
`endif
        rd = 32'h0;
        if (err) return;
        a = int'(off - (off % n));
        if (we) begin
            for (int i = 0; i < n; i++) mdl[a+i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v | (longint'(mdl[a+i]) << (8*i));
            if (!f3[2] && n < 4 && ((v >> (8*n-1)) & 1) == 1) v = v - (longint'(1) << (8*n));
            rd = v[31:0];
        end
    endfunction

    // Every cycle a response is shown it must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (expq.size() == 0) begin
                check("spurious_rsp_valid", 32'(rsp_valid), 32'h0);
            end else begin
                check("rsp_rdata", rsp_rdata, expq[0].rd);
                check("rsp_err", 32'(rsp_err), 32'(expq[0].err));
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && rsp_valid && rsp_ready && expq.size() > 0) void'(expq.pop_front());
    end

    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int hold, input bit lit,
                       input logic [31:0] lit_rd, input logic lit_err);
        exp_t e;
        int   n;
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'h1);
        check("rsp_valid_idle", 32'(rsp_valid), 32'h0);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wd;
        @(posedge clk);
        model(we, f3, addr, wd, e.rd, e.err);
        expq.push_back(e);
        #1;
        // Busy-time request lines carry junk that must be ignored.
        req_we     = 1'($urandom);
        req_addr   = $urandom;
        req_funct3 = 3'($urandom);
        req_wdata  = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!rsp_valid) check("req_ready_wait", 32'(req_ready), 32'h0);
        end while (!rsp_valid && n < 40);
        check("rsp_latency", 32'(n), 32'(LAT + 1));
        if (!rsp_valid) begin
            req_valid = 1'b0;
            return;
        end
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge clk);
            check("rsp_valid_hold", 32'(rsp_valid), 32'h1);
            check("req_ready_busy", 32'(req_ready), 32'h0);
        end
        if (lit) begin
            check("rdata_literal", rsp_rdata, lit_rd);
            check("err_literal", 32'(rsp_err), 32'(lit_err));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic reset_during_store(input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = addr;
        req_funct3 = 3'b010;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("req_ready_in_rst", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rsp_valid_after_rst", 32'(rsp_valid), 32'h0);
        check("req_ready_after_rst", 32'(req_ready), 32'h1);
    endtask

    initial begin
        logic [31:0] mis_rd;
        logic        mis_err;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis_rd  = 32'h0;
        mis_err = 1'b1;
`else
        mis_rd  = 32'hDEAD_BEEF;
        mis_err = 1'b0;
`endif
        for (int i = 0; i < 4*DEPTH; i++) mdl[i] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        //  we    f3      addr          wdata          hold lit lit_rd         lit_err
        run(1'b1, 3'b010, 32'h10,       32'hDEAD_BEEF, 0,   1,  32'h0,         1'b0);
        run(1'b0, 3'b010, 32'h10,       32'h0,         0,   1,  32'hDEAD_BEEF, 1'b0);
        run(1'b1, 3'b010, 32'h20,       32'h8070_FF01, 0,   1,  32'h0,         1'b0);
        run(1'b0, 3'b000, 32'h23,       32'h0,         0,   1,  32'hFFFF_FF80, 1'b0);
        run(1'b0, 3'b100, 32'h23,       32'h0,         0,   1,  32'h0000_0080, 1'b0);
        run(1'b0, 3'b001, 32'h22,       32'h0,         0,   1,  32'hFFFF_8070, 1'b0);
        run(1'b0, 3'b101, 32'h20,       32'h0,         0,   1,  32'h0000_FF01, 1'b0);
        run(1'b1, 3'b010, 32'h30,       32'h0,         0,   0,  32'h0,         1'b0);
        run(1'b1, 3'b000, 32'h31,       32'h0000_00AB, 0,   0,  32'h0,         1'b0);
        run(1'b0, 3'b010, 32'h30,       32'h0,         0,   1,  32'h0000_AB00, 1'b0);
        run(1'b1, 3'b001, 32'h32,       32'h0000_1234, 0,   0,  32'h0,         1'b0);
        run(1'b0, 3'b010, 32'h30,       32'h0,         5,   1,  32'h1234_AB00, 1'b0);
        run(1'b0, 3'b010, 32'h1000,     32'h0,         0,   1,  32'h0,         1'b1);
        run(1'b1, 3'b011, 32'h30,       32'hFFFF_FFFF, 0,   1,  32'h0,         1'b1);
        run(1'b0, 3'b010, 32'h30,       32'h0,         0,   1,  32'h1234_AB00, 1'b0);
        run(1'b0, 3'b110, 32'h30,       32'h0,         0,   1,  32'h0,         1'b1);
        run(1'b0, 3'b010, 32'h11,       32'h0,         0,   1,  mis_rd,        mis_err);
        run(1'b0, 3'b001, 32'h21,       32'h0,         2,   0,  32'h0,         1'b0);
        run(1'b1, 3'b000, 32'hFFFF_FFF0, 32'h55,       0,   1,  32'h0,         1'b1);
        run(1'b1, 3'b001, 32'h13,       32'hCAFE_5AA5, 0,   0,  32'h0,         1'b0);
        run(1'b0, 3'b010, 32'h10,       32'h0,         1,   0,  32'h0,         1'b0);

        reset_during_store(32'h20, 32'h5555_5555);
        run(1'b0, 3'b010, 32'h20,       32'h0,         0,   1,  32'h8070_FF01, 1'b0);

        check("expect_queue_drained", 32'(expq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
